// File: rtl/imem_stim_seq.sv
// Instruction stimulus sequencer: a loadable program buffer played out in timed
// steps or looked up by the CPU's instruction address, feeding imemrdata.
module imem_stim_seq #(
   parameter int               WIDTH    = 16,
   parameter int               DEPTH    = 16,
   parameter int               AW       = 4,
   parameter int               HW       = 8,
   parameter logic [WIDTH-1:0] NOP_WORD = 16'h0000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_data,
   input  logic [AW:0]      prog_len,
   input  logic [HW-1:0]    hold_cycles,
   input  logic             mode,
   input  logic             loop_en,
   input  logic             start,
   input  logic             stop,
   input  logic [15:0]      imemaddr,
   output logic [WIDTH-1:0] instr_out,
   output logic             instr_valid,
   output logic [AW-1:0]    seq_index,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   state_t           state, state_nx;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      len_r, len_nx;
   logic [HW-1:0]    hold_r, hold_nx, cnt, cnt_nx;
   logic             mode_r, mode_nx, loop_r, loop_nx;
   logic [WIDTH-1:0] instr_nx;
   logic             valid_nx;
   logic [AW-1:0]    idx_nx;

   logic             wr_en, start_ok, last, addr_hit;
   logic [HW-1:0]    hold_in;
   logic [WIDTH-1:0] word0;
   logic [AW-1:0]    addr_idx;
   logic             unused_addr_lsb;

   assign wr_en     = load_en && (state != PLAY);
   assign start_ok  = start && (prog_len != '0) && (prog_len <= DEPTH_L);
   assign hold_in   = (hold_cycles == '0) ? HW'(1) : hold_cycles;
   // A load on the start edge must be visible as the first presented word.
   assign word0     = (wr_en && (load_addr == '0)) ? load_data : mem[0];
   assign last      = ({1'b0, seq_index} == (len_r - 1'b1));
   assign addr_idx  = imemaddr[AW:1];
   assign addr_hit  = (imemaddr[15:AW+1] == '0) && ({1'b0, addr_idx} < len_r);
   assign unused_addr_lsb = imemaddr[0];

   assign busy = (state == PLAY);
   assign done = (state == DONE);

   always_ff @(posedge clock) begin
      if (wr_en) mem[load_addr] <= load_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         instr_out   <= NOP_WORD;
         instr_valid <= 1'b0;
         seq_index   <= '0;
         cnt         <= '0;
         len_r       <= '0;
         hold_r      <= '0;
         mode_r      <= 1'b0;
         loop_r      <= 1'b0;
      end else begin
         state       <= state_nx;
         instr_out   <= instr_nx;
         instr_valid <= valid_nx;
         seq_index   <= idx_nx;
         cnt         <= cnt_nx;
         len_r       <= len_nx;
         hold_r      <= hold_nx;
         mode_r      <= mode_nx;
         loop_r      <= loop_nx;
      end
   end

   always_comb begin
      state_nx = state;
      instr_nx = instr_out;
      valid_nx = instr_valid;
      idx_nx   = seq_index;
      cnt_nx   = cnt;
      len_nx   = len_r;
      hold_nx  = hold_r;
      mode_nx  = mode_r;
      loop_nx  = loop_r;
      unique case (state)
         IDLE, DONE: begin
            if (stop && (state == DONE)) begin
               state_nx = IDLE;
               instr_nx = NOP_WORD;
               valid_nx = 1'b0;
               idx_nx   = '0;
            end else if (start_ok) begin
               state_nx = PLAY;
               len_nx   = prog_len;
               hold_nx  = hold_in;
               mode_nx  = mode;
               loop_nx  = loop_en;
               idx_nx   = '0;
               if (!mode) begin
                  instr_nx = word0;
                  valid_nx = 1'b1;
                  cnt_nx   = hold_in - 1'b1;
               end else begin
                  instr_nx = NOP_WORD;
                  valid_nx = 1'b0;
                  cnt_nx   = '0;
               end
            end
         end
         PLAY: begin
            if (stop) begin
               state_nx = IDLE;
               instr_nx = NOP_WORD;
               valid_nx = 1'b0;
               idx_nx   = '0;
            end else if (mode_r) begin
               idx_nx   = addr_idx;
               instr_nx = addr_hit ? mem[addr_idx] : NOP_WORD;
               valid_nx = addr_hit;
            end else if (cnt != '0) begin
               cnt_nx = cnt - 1'b1;
            end else if (!last) begin
               idx_nx   = seq_index + 1'b1;
               instr_nx = mem[seq_index + 1'b1];
               cnt_nx   = hold_r - 1'b1;
            end else if (loop_r) begin
               idx_nx   = '0;
               instr_nx = mem[0];
               cnt_nx   = hold_r - 1'b1;
            end else begin
               state_nx = DONE;
               instr_nx = NOP_WORD;
               valid_nx = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: doc/imem_stim_seq.md
Name: imem_stim_seq

Overview:
- Synthesizable, parametrised instruction stimulus sequencer. It replaces hand-timed instruction pokes into the LEGLitePipe instruction-read port.
- Holds a loadable program buffer of DEPTH words. Each word is presented on instr_out for a programmable number of cycles, or the buffer is indexed by the CPU's imemaddr like a real instruction memory.
- Sits between bench/loader logic and the CPU's imemrdata input. It provides one-shot and loop playback, stop/restart, and a done flag.

Parameters:
- WIDTH, 16, instruction word width.
- DEPTH, 16, program buffer entries (power of two).
- AW, 4, buffer address width, log2(DEPTH).
- HW, 8, width of hold_cycles.
- NOP_WORD, 16'h0000, word driven when no instruction is being presented.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write load_data into buffer[load_addr]; honoured only in IDLE or DONE.
- load_addr  in  AW  buffer write address.
- load_data  in  WIDTH  buffer write data.
- prog_len  in  AW+1  number of valid entries (1..DEPTH); sampled on start.
- hold_cycles  in  HW  cycles each word is held in timed mode; sampled on start; 0 is treated as 1.
- mode  in  1  0 = timed sequence, 1 = address-indexed; sampled on start.
- loop_en  in  1  timed mode only: wrap to entry 0 instead of finishing; sampled on start.
- start  in  1  begin playback; honoured in IDLE or DONE.
- stop  in  1  abort playback; return to IDLE.
- imemaddr  in  16  CPU instruction byte address (used in mode 1).
- instr_out  out  WIDTH  instruction to CPU imemrdata.
- instr_valid  out  1  instr_out holds a buffer word, not NOP_WORD.
- seq_index  out  AW  buffer index currently presented.
- busy  out  1  state == PLAY.
- done  out  1  state == DONE.

Behaviour:
- Reset (async, any state): state IDLE; instr_out = NOP_WORD; instr_valid = 0; seq_index = 0; hold counter = 0; busy = 0; done = 0. Buffer contents are not reset.
- States: IDLE, PLAY, DONE. busy and done are decoded from registered state.
- Load: a write occurs at the clock edge when load_en = 1 and state is IDLE or DONE. load_en in PLAY is ignored and the buffer is unchanged.
- Start:
  - IDLE/DONE with start = 1 and 1 <= prog_len <= DEPTH: latch len, hold (0→1), mode and loop, then go to PLAY on the next edge.
  - prog_len = 0 or > DEPTH: start is ignored.
  - Same edge as load_en: the load is applied first; the new word is visible at index 0 if load_addr = 0.
- Timed mode (mode = 0), registered output:
  - On entering PLAY: instr_out = buf[0], instr_valid = 1, seq_index = 0, hold counter = hold-1.
  - Each PLAY cycle with counter > 0: decrement the counter; hold instr_out.
  - Counter = 0 and seq_index < len-1: seq_index+1; instr_out = buf[next]; counter reloads to hold-1.
  - Counter = 0 and seq_index = len-1, loop = 1: wrap to index 0.
  - Counter = 0 and seq_index = len-1, loop = 0: go to DONE; instr_out = NOP_WORD; instr_valid = 0; seq_index holds len-1.
  - Every word is therefore visible for exactly hold cycles.
- Address-indexed mode (mode = 1), one-cycle read latency:
  - Each PLAY cycle: idx = imemaddr[AW:1] (word address).
  - If imemaddr[15:AW+1] == 0 and idx < len: instr_out = buf[idx], instr_valid = 1.
  - Otherwise: instr_out = NOP_WORD, instr_valid = 0.
  - seq_index = idx. Mode 1 never enters DONE; it exits only on stop or reset.
- Stop: stop = 1 in PLAY → IDLE next edge; instr_out = NOP_WORD; instr_valid = 0; seq_index = 0. stop has priority over the advance on the same edge. stop in IDLE/DONE has no effect except DONE→IDLE.
- Start while PLAY: ignored (stop is required first).
- stop and start on the same edge in DONE: stop wins → IDLE.
- Reset mid-PLAY: immediate IDLE with outputs at reset values; buffer is retained, so a subsequent start replays the same program.

Test Plan:
- Load buf[0..3] = C0F9, C17B, C119, 1C1C; prog_len = 4, hold = 5, mode = 0, loop = 0; pulse start → instr_out is C0F9 for 5 cycles, then C17B, C119, 1C1C (5 each, instr_valid = 1); then done = 1, instr_out = 0000, instr_valid = 0, seq_index = 3.
- Same program, loop = 1, hold = 2 → sequence C0F9, C0F9, C17B, C17B, …, 1C1C, 1C1C, C0F9 repeating; done stays 0; stop → IDLE, instr_out = 0000 the next cycle.
- mode = 1, prog_len = 4; drive imemaddr = 0, 2, 4, 6, 8, 16'h0100 → instr_out one cycle later is C0F9, C17B, C119, 1C1C, 0000 (valid = 0), 0000 (valid = 0).
- hold_cycles = 0, prog_len = 1, buf[0] = C0F9 → C0F9 is presented exactly 1 cycle, then DONE; load_en during PLAY with load_addr = 0, data = FFFF → buf[0] still reads C0F9 on restart.
- Assert reset asynchronously mid-hold of word 2 → outputs go to reset values before the next edge; restart replays from C0F9; start with prog_len = 0 → state stays IDLE.
